// File: rtl/minterm_sweep_ctrl.sv
// Steps a 4-input minterm circuit through i=0..15, holds each vector SETTLE+1 cycles, captures y into a truth table
// and compares it against EXP_MASK. Sweep takes 16*(SETTLE+1) cycles; done pulses one cycle after the last sample.
module minterm_sweep_ctrl #(
  parameter logic [15:0] EXP_MASK = 16'h587E,
  parameter int unsigned SETTLE   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        en_mode,
  input  logic        abort,
  input  logic        y_in,
  output logic [3:0]  i_out,
  output logic        en_out,
  output logic        busy,
  output logic        done,
  output logic [15:0] result,
  output logic [4:0]  err_count,
  output logic [3:0]  first_err,
  output logic        pass
);

  typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

  localparam logic [3:0] SETTLE_W = 4'(SETTLE);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [3:0]  i_n;
  logic        en_n, busy_n, done_n, pass_n;
  logic [15:0] result_n;
  logic [4:0]  err_n;
  logic [3:0]  ferr_n;
  logic        exp_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      i_out     <= '0;
      en_out    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      err_count <= '0;
      first_err <= '0;
      pass      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      i_out     <= i_n;
      en_out    <= en_n;
      busy      <= busy_n;
      done      <= done_n;
      result    <= result_n;
      err_count <= err_n;
      first_err <= ferr_n;
      pass      <= pass_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    i_n      = i_out;
    en_n     = en_out;
    busy_n   = busy;
    done_n   = 1'b0;
    result_n = result;
    err_n    = err_count;
    ferr_n   = first_err;
    pass_n   = pass;
    exp_bit  = en_out & EXP_MASK[i_out];

    case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (start) begin
          state_n  = HOLD;
          en_n     = en_mode;
          i_n      = '0;
          busy_n   = 1'b1;
          result_n = '0;
          err_n    = '0;
          ferr_n   = '0;
          cnt_n    = '0;
        end
      end

      HOLD: begin
        if (abort) begin
          // Partial result/err_count stay visible for debug; pass is left untouched.
          state_n = IDLE;
          busy_n  = 1'b0;
          i_n     = '0;
          en_n    = 1'b0;
          cnt_n   = '0;
        end else if (cnt == SETTLE_W) begin
          result_n[i_out] = y_in;
          if (y_in != exp_bit) begin
            err_n = err_count + 5'd1;
            if (err_count == 5'd0) begin
              ferr_n = i_out;
            end
          end
          if (i_out == 4'd15) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            i_n     = '0;
            pass_n  = (err_n == 5'd0);
          end else begin
            i_n   = i_out + 4'd1;
            cnt_n = '0;
          end
        end else begin
          cnt_n = cnt + 4'd1;
        end
      end

      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_minterm_sweep_ctrl.sv
// Scoreboard bench: stimulus pushes expected sweep outcomes, monitors pop and compare on every done pulse.
module tb_minterm_sweep_ctrl;

  typedef struct {
    logic [15:0] result;
    logic [4:0]  err_count;
    logic [3:0]  first_err;
    logic        pass;
    int          done_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, en_mode = 1'b0, abort = 1'b0, y_in;
  logic [3:0]  i_out;
  logic        en_out, busy, done, pass;
  logic [15:0] result;
  logic [4:0]  err_count;
  logic [3:0]  first_err;

  logic        start3 = 1'b0, en_mode3 = 1'b0, abort3 = 1'b0, y3;
  logic [3:0]  i_out3;
  logic        en_out3, busy3, done3, pass3;
  logic [15:0] result3;
  logic [4:0]  err_count3;
  logic [3:0]  first_err3;

  logic [15:0] exp_mask = 16'h587E;
  int          ymode = 0;   // 0 ideal, 1 stuck-at-1, 2 stuck-at-0
  int          cyc = 0;
  int          vectors = 0;
  int          fails = 0;
  int          age3 = 0;
  logic        pb3 = 1'b0;
  logic [3:0]  pi3 = 4'd0;
  exp_t        q1[$];
  exp_t        q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign y_in = (ymode == 1) ? 1'b1 : (ymode == 2) ? 1'b0 : (en_out & exp_mask[i_out]);

  // SETTLE=3 instance sees the wrong value for the first 3 cycles of every vector.
  always @(posedge clk) begin
    #1;
    if (!busy3 || !pb3 || i_out3 != pi3) age3 = 0;
    else age3 = age3 + 1;
    pb3 = busy3;
    pi3 = i_out3;
  end
  assign y3 = (age3 < 3) ? ~(en_out3 & exp_mask[i_out3]) : (en_out3 & exp_mask[i_out3]);

  minterm_sweep_ctrl #(.EXP_MASK(16'h587E), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .en_mode(en_mode), .abort(abort), .y_in(y_in),
    .i_out(i_out), .en_out(en_out), .busy(busy), .done(done), .result(result),
    .err_count(err_count), .first_err(first_err), .pass(pass)
  );

  minterm_sweep_ctrl #(.EXP_MASK(16'h587E), .SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .en_mode(en_mode3), .abort(abort3), .y_in(y3),
    .i_out(i_out3), .en_out(en_out3), .busy(busy3), .done(done3), .result(result3),
    .err_count(err_count3), .first_err(first_err3), .pass(pass3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic sb_compare(input string tag, input exp_t e, input logic [15:0] r, input logic [4:0] ec,
                            input logic [3:0] fe, input logic p, input logic b, input logic [3:0] io);
    chk({tag, " result"}, 32'(r), 32'(e.result));
    chk({tag, " err_count"}, 32'(ec), 32'(e.err_count));
    chk({tag, " first_err"}, 32'(fe), 32'(e.first_err));
    chk({tag, " pass"}, 32'(p), 32'(e.pass));
    chk({tag, " busy_at_done"}, 32'(b), 32'd0);
    chk({tag, " i_out_at_done"}, 32'(io), 32'd0);
    chk({tag, " done_cycle"}, 32'(cyc), 32'(e.done_cyc));
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (q1.size() == 0) begin
        vectors++; fails++;
        $display("FAIL dut1 unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        sb_compare("dut1", q1.pop_front(), result, err_count, first_err, pass, busy, i_out);
      end
    end
  end

  always @(negedge clk) begin
    if (done3 === 1'b1) begin
      if (q3.size() == 0) begin
        vectors++; fails++;
        $display("FAIL dut3 unexpected_done: got done=1, expected none (cycle %0d)", cyc);
      end else begin
        sb_compare("dut3", q3.pop_front(), result3, err_count3, first_err3, pass3, busy3, i_out3);
      end
    end
  end

  // Called at a negedge: acceptance happens at the next posedge.
  task automatic start_sweep(input logic en, input bit push, input logic [15:0] r,
                             input logic [4:0] ec, input logic [3:0] fe, input logic p);
    exp_t e;
    e.result = r; e.err_count = ec; e.first_err = fe; e.pass = p;
    e.done_cyc = cyc + 1 + 32;
    if (push) q1.push_back(e);
    en_mode = en;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_q1(input int limit);
    int n = 0;
    while (q1.size() != 0 && n < limit) begin
      @(negedge clk); #1;
      n++;
    end
    if (q1.size() != 0) begin
      vectors++; fails++;
      $display("FAIL dut1 done_timeout: got no done, expected %0d pending", q1.size());
      q1.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_i(input logic [3:0] v, input int limit);
    int n = 0;
    while (i_out !== v && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (i_out !== v) begin
      vectors++; fails++;
      $display("FAIL wait_i_out: got 0x%0h, expected 0x%0h", i_out, v);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " i_out"}, 32'(i_out), 32'd0);
    chk({tag, " en_out"}, 32'(en_out), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " done"}, 32'(done), 32'd0);
    chk({tag, " result"}, 32'(result), 32'd0);
    chk({tag, " err_count"}, 32'(err_count), 32'd0);
    chk({tag, " first_err"}, 32'(first_err), 32'd0);
    chk({tag, " pass"}, 32'(pass), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e3;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");

    // Ideal enabled sweep, with cycle-by-cycle vector trace.
    ymode = 0;
    start_sweep(1'b1, 1'b1, 16'h587E, 5'd0, 4'd0, 1'b1);
    for (int j = 0; j < 32; j++) begin
      chk("trace i_out", 32'(i_out), 32'(j / 2));
      chk("trace busy", 32'(busy), 32'd1);
      if (j == 0) chk("trace en_out", 32'(en_out), 32'd1);
      @(negedge clk);
    end
    wait_q1(10);

    // Enable low: circuit outputs 0 everywhere, which is what's expected.
    start_sweep(1'b0, 1'b1, 16'h0000, 5'd0, 4'd0, 1'b1);
    chk("en0 en_out", 32'(en_out), 32'd0);
    wait_q1(40);

    ymode = 1;
    start_sweep(1'b1, 1'b1, 16'hFFFF, 5'd7, 4'd0, 1'b0);
    wait_q1(40);
    ymode = 2;
    start_sweep(1'b1, 1'b1, 16'h0000, 5'd9, 4'd1, 1'b0);
    wait_q1(40);

    // start pulsed mid-sweep with en_mode flipped: must not restart or relatch.
    ymode = 0;
    start_sweep(1'b1, 1'b1, 16'h587E, 5'd0, 4'd0, 1'b1);
    wait_i(4'd5, 40);
    en_mode = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_start en_out", 32'(en_out), 32'd1);
    wait_q1(40);

    // Leave pass=0 so abort can be seen to preserve it.
    ymode = 2;
    start_sweep(1'b1, 1'b1, 16'h0000, 5'd9, 4'd1, 1'b0);
    wait_q1(40);
    ymode = 0;
    start_sweep(1'b1, 1'b0, 16'h0, 5'd0, 4'd0, 1'b0);
    wait_i(4'd5, 40);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    chk("abort i_out", 32'(i_out), 32'd0);
    chk("abort en_out", 32'(en_out), 32'd0);
    chk("abort pass", 32'(pass), 32'd0);
    chk("abort result", 32'(result), 32'h001E);
    chk("abort err_count", 32'(err_count), 32'd0);
    repeat (40) @(negedge clk);
    chk("abort still_idle", 32'(busy), 32'd0);

    // rst mid-sweep.
    start_sweep(1'b1, 1'b0, 16'h0, 5'd0, 4'd0, 1'b0);
    wait_i(4'd9, 40);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("rst_mid");
    repeat (40) @(negedge clk);
    chk("rst_mid still_idle", 32'(busy), 32'd0);

    // rst together with start in IDLE.
    rst = 1'b1; start = 1'b1; en_mode = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk_reset_vals("rst_start");
    repeat (3) @(negedge clk);
    chk("rst_start no_sweep", 32'(busy), 32'd0);

    // SETTLE=3 instance with early-cycle glitches.
    e3.result = 16'h587E; e3.err_count = 5'd0; e3.first_err = 4'd0; e3.pass = 1'b1;
    e3.done_cyc = cyc + 1 + 64;
    q3.push_back(e3);
    en_mode3 = 1'b1; start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    for (int n = 0; n < 80 && q3.size() != 0; n++) begin
      @(negedge clk); #1;
    end
    if (q3.size() != 0) begin
      vectors++; fails++;
      $display("FAIL dut3 done_timeout: got no done, expected 1 pending");
      q3.delete();
    end
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
